// File: rtl/mux_pkg.sv
// Shared types and helpers for the streaming mux family.
package mux_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Index width that stays at least one bit wide, so n=1 still has a usable select port.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_pick_nv.sv
// Rotating-start priority search: first set req bit at or after start, wrapping at n-1 -> 0.
// With start held at zero this is a plain lowest-index-wins picker.
module prio_pick_nv
  import mux_pkg::*;
#(
  parameter int  n     = 4,
  localparam int sel_w = clog2_min1(n)
) (
  input  logic [n-1:0]     req,
  input  logic [sel_w-1:0] start,
  output logic [sel_w-1:0] gnt,
  output logic             found
);

  // One spare bit so start + offset cannot overflow before the wrap.
  localparam int iw = sel_w + 1;
  typedef logic [iw-1:0] idx_t;

  idx_t idx;

  // NOTE: every output of this block is given a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    // Walk offsets from farthest to nearest; the nearest requester overwrites last and wins.
    for (int k = n - 1; k >= 0; k--) begin
      idx = idx_t'(start) + idx_t'(k);
      if (idx >= idx_t'(n)) idx = idx - idx_t'(n);
      if (req[idx[sel_w-1:0]]) begin
        gnt   = idx[sel_w-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_muxnv.sv
// arb_muxnv: N-to-1 valid/ready stream mux with fixed or round-robin arbitration,
// one registered output slot and burst locking driven by in_last.
module arb_muxnv
  import mux_pkg::*;
#(
  parameter int        width = 32,
  parameter int        n     = 4,
  parameter arb_mode_e mode  = ARB_RR,
  localparam int       sel_w = clog2_min1(n)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [n-1:0]       in_valid,
  input  logic [n-1:0]       in_last,
  input  logic [n*width-1:0] in_data,
  output logic [n-1:0]       in_ready,
  output logic               out_valid,
  output logic               out_last,
  output logic [width-1:0]   out_data,
  output logic [sel_w-1:0]   out_sel,
  input  logic               out_ready
);

  logic             locked;
  logic [sel_w-1:0] lock_idx;
  logic [sel_w-1:0] rr_ptr;
  logic [sel_w-1:0] pick_start;
  logic [sel_w-1:0] pick_gnt;
  logic [sel_w-1:0] gnt;
  logic             pick_found;
  logic             any_req;
  logic             can_take;
  logic             accept;
  logic             sel_last;
  logic [n-1:0]     gnt_oh;
  logic [width-1:0] sel_data;

  assign pick_start = (mode == ARB_RR) ? rr_ptr : '0;

  prio_pick_nv #(.n(n)) u_pick (
    .req   (in_valid),
    .start (pick_start),
    .gnt   (pick_gnt),
    .found (pick_found)
  );

  // A held lock keeps the grant on the burst owner even while it idles.
  assign gnt      = locked ? lock_idx : pick_gnt;
  assign any_req  = locked | pick_found;
  assign can_take = ~out_valid | out_ready;

  always_comb begin
    gnt_oh   = '0;
    sel_data = '0;
    for (int i = 0; i < n; i++) begin
      gnt_oh[i] = (gnt == sel_w'(i));
      sel_data  = sel_data | (in_data[i*width +: width] & {width{gnt_oh[i]}});
    end
  end

  assign sel_last = |(in_last & gnt_oh);
  assign in_ready = {n{~reset & can_take & any_req}} & gnt_oh;
  assign accept   = |(in_valid & in_ready);

  // NOTE: all state here is control or a single data slot, so every register takes the reset value; there is no array to leave unreset.
  // NOTE: non-blocking assignments so each register updates from the values present before the edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      locked    <= 1'b0;
      lock_idx  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_last  <= sel_last;
        out_sel   <= gnt;
        locked    <= ~sel_last;
        lock_idx  <= gnt;
        if (sel_last && (mode == ARB_RR)) begin
          rr_ptr <= (gnt == sel_w'(n - 1)) ? '0 : gnt + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_muxnv.sv
// Bench for arb_muxnv in four configurations (n=4 RR, n=4 FIXED, n=3 RR, n=1), each with
// directed and random streams checked by a scoreboard fed from a transaction-level model.
module tb_arb_muxnv;
  import mux_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          sel;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : cfg
    localparam int        N  = (g == 2) ? 3 : ((g == 3) ? 1 : 4);
    localparam arb_mode_e M  = (g == 1) ? ARB_FIXED : ARB_RR;
    localparam int        SW = (N > 1) ? $clog2(N) : 1;

    logic            reset     = 1'b1;
    logic [N-1:0]    in_valid  = '0;
    logic [N-1:0]    in_last   = '0;
    logic [N*32-1:0] in_data   = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic            out_last;
    logic [31:0]     out_data;
    logic [SW-1:0]   out_sel;
    logic            out_ready = 1'b0;

    arb_muxnv #(.width(32), .n(N), .mode(M)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
    );

    // Per-channel source stores: each channel presents its oldest beat until it is taken.
    logic [31:0] s_data [N][256];
    logic        s_last [N][256];
    int          s_head [N];
    int          s_tail [N];
    bit          hold   [N];

    exp_t sb[$];
    int   got_sel[$];
    int   want_sel[$];
    bit   log_on     = 1'b0;
    bit   check_zero = 1'b0;

    // Reference model state: slot occupancy, round-robin start, burst owner (-1 = none).
    bit m_full  = 1'b0;
    int m_ptr   = 0;
    int m_owner = -1;

    int valid_pct  = 100;
    int ready_pct  = 100;
    int stall_left = 0;

    function automatic string nm(input string s);
      return $sformatf("cfg%0d %s", g, s);
    endfunction

    function automatic bit idle();
      bit r = (sb.size() == 0) && !m_full;
      for (int i = 0; i < N; i++) if (s_head[i] != s_tail[i]) r = 1'b0;
      return r;
    endfunction

    task automatic load(input int ch, input logic [31:0] d, input logic l);
      s_data[ch][s_tail[ch] % 256] = d;
      s_last[ch][s_tail[ch] % 256] = l;
      s_tail[ch]++;
    endtask

    task automatic load_burst(input int ch);
      int len = int'($urandom_range(4, 1));
      for (int b = 0; b < len; b++) load(ch, $urandom, b == len - 1);
    endtask

    task automatic add_want(input int s);
      want_sel.push_back(s);
    endtask

    task automatic cycle();
      logic [N-1:0] exp_rdy;
      int           win;
      int           c;
      bit           can_take;
      bit           acc;
      exp_t         e;
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!hold[i] && s_head[i] != s_tail[i] && $urandom_range(99) < valid_pct) hold[i] = 1'b1;
        in_valid[i]         = hold[i];
        in_data[i*32 +: 32] = hold[i] ? s_data[i][s_head[i] % 256] : $urandom;
        in_last[i]          = hold[i] ? s_last[i][s_head[i] % 256] : 1'($urandom);
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      #1;
      check(nm("out_valid"), out_valid, m_full);
      if (check_zero) begin
        check(nm("reset_data"), out_data, 0);
        check(nm("reset_sel"), out_sel, 0);
        check(nm("reset_last"), out_last, 0);
        check_zero = 1'b0;
      end else if (m_full && sb.size() > 0) begin
        check(nm("slot_data"), out_data, sb[0].data);
        check(nm("slot_last"), out_last, sb[0].last);
        check(nm("slot_sel"), out_sel, sb[0].sel);
      end
      // Grant from the rules: burst owner if any, else first valid channel from the start point.
      can_take = !m_full || out_ready;
      win      = m_owner;
      if (win < 0) begin
        for (int k = 0; k < N; k++) begin
          c = (((M == ARB_RR) ? m_ptr : 0) + k) % N;
          if (hold[c]) begin
            win = c;
            break;
          end
        end
      end
      exp_rdy = '0;
      if (win >= 0 && can_take) exp_rdy[win] = 1'b1;
      check(nm("in_ready"), in_ready, exp_rdy);
      acc = (win >= 0) && can_take && hold[win];
      if (acc) begin
        e.data = s_data[win][s_head[win] % 256];
        e.last = s_last[win][s_head[win] % 256];
        e.sel  = win;
        sb.push_back(e);
        s_head[win]++;
        hold[win] = 1'b0;
        if (e.last) begin
          m_owner = -1;
          if (M == ARB_RR) m_ptr = (win + 1) % N;
        end else begin
          m_owner = win;
        end
        m_full = 1'b1;
      end else if (out_ready) begin
        m_full = 1'b0;
      end
    endtask

    task automatic run(input int k);
      for (int t = 0; t < k; t++) cycle();
    endtask

    // One reset cycle with every channel claiming valid, so in_ready gating is observable.
    task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      in_valid  = '1;
      out_ready = 1'b0;
      for (int i = 0; i < N; i++) begin
        hold[i]   = 1'b0;
        s_head[i] = s_tail[i];
      end
      sb.delete();
      m_full     = 1'b0;
      m_ptr      = 0;
      m_owner    = -1;
      stall_left = 0;
      #1;
      check(nm("in_ready_in_reset"), in_ready, '0);
      check_zero = 1'b1;
    endtask

    always @(negedge clock) begin
      exp_t e;
      #2;
      if (reset !== 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
        check(nm("beat_expected"), 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check(nm("beat_data"), out_data, e.data);
          check(nm("beat_last"), out_last, e.last);
          check(nm("beat_sel"), out_sel, e.sel);
          if (log_on) got_sel.push_back(int'(out_sel));
        end
      end
    end

    initial begin
      for (int i = 0; i < N; i++) begin
        s_head[i] = 0;
        s_tail[i] = 0;
        hold[i]   = 1'b0;
      end
      do_reset();

      // Logged grant order for the headline scenario of each configuration.
      log_on = 1'b1;
      case (g)
        0: begin
          for (int i = 0; i < 4; i++) load(i, 32'hA0 + i, 1'b1);
          load(0, 32'hA4, 1'b1);
          add_want(0); add_want(1); add_want(2); add_want(3); add_want(0);
        end
        1: begin
          for (int b = 0; b < 3; b++) load(1, 32'h10 + b, 1'b1);
          load(3, 32'h30, 1'b1);
          add_want(1); add_want(1); add_want(1); add_want(3);
        end
        2: begin
          load(1, 32'h21, 1'b1);
          run(3);
          load(0, 32'h20, 1'b1);
          run(3);
          load(1, 32'h22, 1'b1);
          load(2, 32'h23, 1'b1);
          add_want(1); add_want(0); add_want(1); add_want(2);
        end
        default: begin
          load(0, 32'h1, 1'b0);
          load(0, 32'h2, 1'b0);
          load(0, 32'h3, 1'b1);
          add_want(0); add_want(0); add_want(0);
        end
      endcase
      run(10);
      log_on = 1'b0;
      check(nm("grant_count"), got_sel.size(), want_sel.size());
      for (int i = 0; i < want_sel.size() && i < got_sel.size(); i++)
        check(nm("grant_order"), got_sel[i], want_sel[i]);

      if (g == 0) begin
        // Burst on ch2 with ch0 waiting; then ch0/ch3 together exposes the pointer after the burst.
        load(1, 32'h11, 1'b1);
        run(3);
        load(0, 32'hC0, 1'b1);
        load(2, 32'hB0, 1'b0);
        load(2, 32'hB1, 1'b0);
        load(2, 32'hB2, 1'b1);
        run(8);
        load(0, 32'hC1, 1'b1);
        load(3, 32'hD3, 1'b1);
        run(4);
        // Backpressure: beat held for five stalled cycles while ch1 waits.
        load(3, 32'hDEADBEEF, 1'b1);
        run(1);
        stall_left = 5;
        load(1, 32'h55, 1'b1);
        run(9);
        // Reset after the first beat of a ch1 burst, with the pointer away from zero.
        for (int b = 0; b < 4; b++) load(1, 32'h60 + b, b == 3);
        run(1);
        do_reset();
        load(0, 32'h70, 1'b1);
        load(1, 32'h64, 1'b1);
        load(3, 32'h73, 1'b1);
        run(6);
      end

      valid_pct = 60;
      ready_pct = 70;
      for (int t = 0; t < 1500; t++) begin
        for (int i = 0; i < N; i++)
          if (s_tail[i] - s_head[i] < 6 && $urandom_range(7) == 0) load_burst(i);
        if ($urandom_range(399) == 0) do_reset();
        else cycle();
      end

      valid_pct = 100;
      ready_pct = 100;
      for (int t = 0; t < 300 && !idle(); t++) cycle();
      check(nm("drained"), 64'(idle()), 1);
      done_cnt++;
    end
  end

  initial begin
    for (int t = 0; t < 20000 && done_cnt < 4; t++) @(posedge clock);
    check("all_configs_done", 64'(done_cnt), 64'd4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
